// File: rtl/br_flow_join_multihot_pkg.sv
// Shared defaults for the multihot join block and its interface.
package br_flow_join_multihot_pkg;

  localparam int DefaultNumFlows = 2;
  localparam int DefaultWidth    = 1;

endpackage

// File: rtl/br_flow_join_multihot_if.sv
// Handshake bundle for the multihot join: select flow, per-flow push, combined pop.
interface br_flow_join_multihot_if
  import br_flow_join_multihot_pkg::*;
#(
  parameter int NumFlows = DefaultNumFlows,
  parameter int Width    = DefaultWidth
);

  logic                             select_ready;
  logic                             select_valid;
  logic [NumFlows-1:0]              select_multihot;
  logic [NumFlows-1:0]              push_ready;
  logic [NumFlows-1:0]              push_valid;
  logic [NumFlows-1:0][Width-1:0]   push_data;
  logic                             pop_ready;
  logic                             pop_valid;
  logic [NumFlows-1:0]              pop_mask;
  logic [NumFlows-1:0][Width-1:0]   pop_data;

  // Producer/consumer side of the join.
  modport master (
    input  select_ready,
    output select_valid,
    output select_multihot,
    input  push_ready,
    output push_valid,
    output push_data,
    output pop_ready,
    input  pop_valid,
    input  pop_mask,
    input  pop_data
  );

  // The join block itself.
  modport slave (
    output select_ready,
    input  select_valid,
    input  select_multihot,
    output push_ready,
    input  push_valid,
    input  push_data,
    input  pop_ready,
    output pop_valid,
    output pop_mask,
    output pop_data
  );

endinterface

// File: rtl/br_flow_join_multihot_lane.sv
// One push lane of the join: captures a single beat per transaction and
// remembers that it has done so until the next select clears it.
module br_flow_join_multihot_lane #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             collect,
  input  logic             sel,
  input  logic             push_valid,
  input  logic [Width-1:0] push_data,
  output logic             push_ready,
  output logic             accepted,
  output logic             got,
  output logic [Width-1:0] data
);

  logic             got_q;
  logic [Width-1:0] data_q;

  // Only a selected lane that has not yet captured its beat may accept.
  assign push_ready = collect & sel & ~got_q;
  assign accepted   = push_valid & push_ready;
  assign got        = got_q;
  assign data       = data_q;

  // Got flag: set on capture, dropped on reset or when a new select arrives.
  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      got_q <= 1'b0;
    end else if (accepted) begin
      got_q <= 1'b1;
    end
  end

  // Captured beat.
  // NOTE: the data register is deliberately left without reset; stale contents
  // are never visible because the top masks pop_data by state and select.
  always_ff @(posedge clk) begin
    if (accepted) begin
      data_q <= push_data;
    end
  end

endmodule

// File: rtl/br_flow_join_multihot.sv
// Multihot join: gathers one beat from every flow named by the select, then
// presents them as a single registered, stable pop beat.
module br_flow_join_multihot
  import br_flow_join_multihot_pkg::*;
#(
  parameter int NumFlows                  = DefaultNumFlows,
  parameter int Width                     = DefaultWidth,
  parameter bit EnableAssertFinalNotValid = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  br_flow_join_multihot_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain
  } state_e;

  state_e                         state_q;
  logic [NumFlows-1:0]            sel_q;
  logic [NumFlows-1:0]            lane_push_ready;
  logic [NumFlows-1:0]            lane_accepted;
  logic [NumFlows-1:0]            lane_got;
  logic [NumFlows-1:0][Width-1:0] lane_data;
  logic [NumFlows-1:0][Width-1:0] pop_data;
  logic                           select_ready;
  logic                           select_fire;
  logic                           collect;
  logic                           drain;
  logic                           done;

  assign collect     = (state_q == StCollect);
  assign drain       = (state_q == StDrain);
  assign select_fire = bus.select_valid & select_ready;
  // Pushes landing this cycle count, so a full set of valids completes in one cycle.
  assign done        = collect && ((lane_got | lane_accepted) == sel_q);

  for (genvar i = 0; i < NumFlows; i++) begin : gen_lane
    br_flow_join_multihot_lane #(
      .Width (Width)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .clear      (select_fire),
      .collect    (collect),
      .sel        (sel_q[i]),
      .push_valid (bus.push_valid[i]),
      .push_data  (bus.push_data[i]),
      .push_ready (lane_push_ready[i]),
      .accepted   (lane_accepted[i]),
      .got        (lane_got[i]),
      .data       (lane_data[i])
    );
  end

  // Select is open when idle, and in drain only alongside a pop (back-to-back).
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    select_ready = 1'b0;
    unique case (state_q)
      StIdle:  select_ready = 1'b1;
      StDrain: select_ready = bus.pop_ready;
      default: select_ready = 1'b0;
    endcase
  end

  // Pop lanes carry captured data only while draining and only where selected.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < NumFlows; i++) begin
      if (drain && sel_q[i]) begin
        pop_data[i] = lane_data[i];
      end
    end
  end

  assign bus.select_ready = select_ready;
  assign bus.push_ready   = lane_push_ready;
  assign bus.pop_valid    = drain;
  assign bus.pop_mask     = drain ? sel_q : '0;
  assign bus.pop_data     = pop_data;

  // Transaction sequencer: latch select, wait for all selected beats, hold pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.select_valid) begin
            sel_q   <= bus.select_multihot;
            state_q <= StCollect;
          end
        end
        StCollect: begin
          if (done) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (bus.pop_ready) begin
            if (bus.select_valid) begin
              sel_q   <= bus.select_multihot;
              state_q <= StCollect;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Upstream obligations.
  a_select_nonzero: assert property (@(posedge clk) disable iff (rst)
    bus.select_valid |-> (bus.select_multihot != '0));
  a_select_stable: assert property (@(posedge clk) disable iff (rst)
    bus.select_valid && !bus.select_ready |=>
      bus.select_valid && $stable(bus.select_multihot));

  for (genvar i = 0; i < NumFlows; i++) begin : gen_push_chk
    a_push_stable: assert property (@(posedge clk) disable iff (rst)
      bus.push_valid[i] && !bus.push_ready[i] |=>
        bus.push_valid[i] && $stable(bus.push_data[i]));
  end

  // Block guarantees.
  a_pop_stable: assert property (@(posedge clk) disable iff (rst)
    bus.pop_valid && !bus.pop_ready |=>
      bus.pop_valid && $stable(bus.pop_mask) && $stable(bus.pop_data));
  a_pop_mask_nonzero: assert property (@(posedge clk) disable iff (rst)
    bus.pop_valid |-> (bus.pop_mask != '0));
  a_push_ready_legal: assert property (@(posedge clk) disable iff (rst)
    (bus.push_ready & ~(sel_q & ~lane_got)) == '0);

  // Nothing may be left in flight when simulation ends.
  final begin
    if (EnableAssertFinalNotValid) begin
      a_final_select: assert (!bus.select_valid);
      a_final_push:   assert (bus.push_valid == '0);
      a_final_pop:    assert (!bus.pop_valid);
    end
  end
`endif

endmodule
